// File: rtl/pic_pkg.sv
// Shared definitions for the pic_core_n interrupt controller: register map, CTRL/EOI bits, FSM states.
// Latency: n/a (definitions only); backpressure: n/a.
package pic_pkg;

  localparam logic [2:0] ADDR_CTRL  = 3'd0;
  localparam logic [2:0] ADDR_VBASE = 3'd1;
  localparam logic [2:0] ADDR_IMR   = 3'd2;
  localparam logic [2:0] ADDR_EOI   = 3'd3;
  localparam logic [2:0] ADDR_IRR   = 3'd4;
  localparam logic [2:0] ADDR_ISR   = 3'd5;
  localparam logic [2:0] ADDR_PRIO  = 3'd6;

  localparam int CTRL_LTIM = 0;
  localparam int CTRL_AEOI = 1;
  localparam int CTRL_ROT  = 2;

  localparam int EOI_SPEC = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    VEC  = 2'd2
  } pic_state_t;

  // Rank 0 is the highest priority: the line just after prio_low.
  function automatic int prio_rank(input int line, input int low, input int n);
    return (line + n - (low % n) - 1) % n;
  endfunction

endpackage

// File: rtl/pic_prio_rot.sv
// Combinational rotating priority resolver: line prio_low+1 (mod N) is highest, prio_low lowest.
// Latency: 0 cycles (pure combinational); backpressure: none.
module pic_prio_rot #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] prio_low,
  output logic          found,
  output logic [IW-1:0] idx
);

  function automatic logic [IW-1:0] line_at(input logic [IW-1:0] low, input int ofs);
    return IW'((int'(low) + 1 + ofs) % N);
  endfunction

  // Walk from the lowest-priority offset upward so the last hit is the winner.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[line_at(prio_low, j)]) begin
        found = 1'b1;
        idx   = line_at(prio_low, j);
      end
    end
  end

endmodule

// File: rtl/pic_core_n.sv
// 8259-style interrupt controller core: IRR/ISR/IMR, fixed/rotating priority, int/inta vector handshake.
// Latency: irq edge to int_o = 3 cycles, inta to vec_valid = 1 cycle; backpressure: none, inta is a pulse.
module pic_core_n #(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               cfg_wr,
  input  logic               cfg_rd,
  input  logic [2:0]         cfg_addr,
  input  logic [15:0]        cfg_wdata,
  output logic [15:0]        cfg_rdata,
  output logic               int_o,
  input  logic               inta,
  output logic [VEC_W-1:0]   vec,
  output logic               vec_valid
);
  import pic_pkg::*;

  localparam int IDX_W = $clog2(NUM_IRQ);

  logic [NUM_IRQ-1:0] irq_q, irq_qq;
  logic [NUM_IRQ-1:0] irr, isr, imr;
  logic [2:0]         ctrl;
  logic [VEC_W-1:0]   vbase;
  logic [IDX_W-1:0]   prio_low;
  pic_state_t         state;

  logic ltim, aeoi, rot;
  assign ltim = ctrl[CTRL_LTIM];
  assign aeoi = ctrl[CTRL_AEOI];
  assign rot  = ctrl[CTRL_ROT];

  function automatic logic [NUM_IRQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return NUM_IRQ'(1) << i;
  endfunction

  logic [NUM_IRQ-1:0] req;
  logic               req_found, isr_found;
  logic [IDX_W-1:0]   req_idx, isr_idx;

  assign req = irr & ~imr;

  pic_prio_rot #(.N(NUM_IRQ), .IW(IDX_W)) u_req_prio (
    .req      (req),
    .prio_low (prio_low),
    .found    (req_found),
    .idx      (req_idx)
  );

  pic_prio_rot #(.N(NUM_IRQ), .IW(IDX_W)) u_isr_prio (
    .req      (isr),
    .prio_low (prio_low),
    .found    (isr_found),
    .idx      (isr_idx)
  );

  logic pend;
  assign pend = req_found &&
                (!isr_found ||
                 prio_rank(int'(req_idx), int'(prio_low), NUM_IRQ) <
                 prio_rank(int'(isr_idx), int'(prio_low), NUM_IRQ));

  logic               grant;
  logic [NUM_IRQ-1:0] grant_oh;
  assign grant    = (state == REQ) && inta && pend;
  assign grant_oh = onehot(req_idx);

  // EOI is resolved against the ISR as it stands before any same-cycle grant.
  logic             eoi_wr, eoi_hit;
  logic [IDX_W-1:0] eoi_idx;
  assign eoi_wr = cfg_wr && (cfg_addr == ADDR_EOI);

  always_comb begin
    eoi_idx = cfg_wdata[IDX_W-1:0];
    eoi_hit = 1'b0;
    if (eoi_wr) begin
      if (cfg_wdata[EOI_SPEC]) begin
        eoi_hit = |(isr & onehot(eoi_idx));
      end else begin
        eoi_idx = isr_idx;
        eoi_hit = isr_found;
      end
    end
  end

  logic [NUM_IRQ-1:0] eoi_clr, irr_clr, isr_set, edge_set;
  assign eoi_clr  = eoi_hit ? onehot(eoi_idx) : '0;
  assign irr_clr  = (grant && !ltim) ? grant_oh : '0;
  assign isr_set  = (grant && !aeoi) ? grant_oh : '0;
  assign edge_set = irq_q & ~irq_qq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q  <= '0;
      irq_qq <= '0;
      irr    <= '0;
      isr    <= '0;
    end else begin
      irq_q  <= irq;
      irq_qq <= irq_q;
      irr    <= ltim ? irq_q : ((irr & ~irr_clr) | edge_set);
      isr    <= (isr & ~eoi_clr) | isr_set;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl     <= '0;
      vbase    <= '0;
      imr      <= '1;
      prio_low <= IDX_W'(NUM_IRQ - 1);
    end else begin
      if (cfg_wr && cfg_addr == ADDR_CTRL)  ctrl  <= cfg_wdata[2:0];
      if (cfg_wr && cfg_addr == ADDR_VBASE) vbase <= cfg_wdata[VEC_W-1:0];
      if (cfg_wr && cfg_addr == ADDR_IMR)   imr   <= cfg_wdata[NUM_IRQ-1:0];
      // An auto-EOI rotation outranks an EOI rotation, which outranks a direct PRIO write.
      if (grant && aeoi && rot) begin
        prio_low <= req_idx;
      end else if (eoi_hit && rot) begin
        prio_low <= eoi_idx;
      end else if (cfg_wr && cfg_addr == ADDR_PRIO) begin
        prio_low <= cfg_wdata[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      int_o     <= 1'b0;
      vec       <= '0;
      vec_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pend) begin
            state <= REQ;
            int_o <= 1'b1;
          end
        end
        REQ: begin
          if (inta) begin
            state     <= VEC;
            int_o     <= 1'b0;
            vec_valid <= 1'b1;
            vec       <= vbase + (pend ? VEC_W'(req_idx) : VEC_W'(NUM_IRQ - 1));
          end else if (!pend) begin
            state <= IDLE;
            int_o <= 1'b0;
          end
        end
        VEC: begin
          state     <= IDLE;
          vec_valid <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          int_o     <= 1'b0;
          vec_valid <= 1'b0;
        end
      endcase
    end
  end

  logic [15:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    case (cfg_addr)
      ADDR_CTRL:  rd_mux = 16'(ctrl);
      ADDR_VBASE: rd_mux = 16'(vbase);
      ADDR_IMR:   rd_mux = 16'(imr);
      ADDR_IRR:   rd_mux = 16'(irr);
      ADDR_ISR:   rd_mux = 16'(isr);
      ADDR_PRIO:  rd_mux = 16'(prio_low);
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_rdata <= '0;
    end else if (cfg_rd) begin
      cfg_rdata <= rd_mux;
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata;

endmodule

// File: tb/tb_pic_core_n.sv
// Directed bench for pic_core_n: 8-line instance for the main scenarios, 16-line instance for the wide index.
// Latency: n/a; backpressure: n/a.
module tb_pic_core_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq;
  logic        cfg_wr, cfg_rd, inta;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_wdata, cfg_rdata;
  logic        int_o, vec_valid;
  logic [7:0]  vec;

  logic [15:0] irq16;
  logic        cfg_wr16, cfg_rd16, inta16;
  logic [2:0]  cfg_addr16;
  logic [15:0] cfg_wdata16, cfg_rdata16;
  logic        int16, vec_valid16;
  logic [7:0]  vec16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pic_core_n #(.NUM_IRQ(8), .VEC_W(8)) dut (
    .clk(clk), .reset(rst), .irq(irq), .cfg_wr(cfg_wr), .cfg_rd(cfg_rd),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .int_o(int_o), .inta(inta), .vec(vec), .vec_valid(vec_valid)
  );

  pic_core_n #(.NUM_IRQ(16), .VEC_W(8)) dut16 (
    .clk(clk), .reset(rst), .irq(irq16), .cfg_wr(cfg_wr16), .cfg_rd(cfg_rd16),
    .cfg_addr(cfg_addr16), .cfg_wdata(cfg_wdata16), .cfg_rdata(cfg_rdata16),
    .int_o(int16), .inta(inta16), .vec(vec16), .vec_valid(vec_valid16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cfg_addr  = a;
    cfg_wdata = d;
    cfg_wr    = 1'b1;
    cyc();
    cfg_wr    = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    cfg_addr = a;
    cfg_rd   = 1'b1;
    cyc();
    cfg_rd   = 1'b0;
    d        = cfg_rdata;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input int exp);
    logic [15:0] d;
    rd(a, d);
    chk(tag, 32'(d), exp);
  endtask

  task automatic wait_int(input string tag);
    int n = 0;
    while (!int_o && n < 20) begin
      cyc();
      n++;
    end
    chk(tag, 32'(int_o), 1);
  endtask

  task automatic ack(input string tag, input int exp);
    inta = 1'b1;
    cyc();
    inta = 1'b0;
    chk({tag, "_vv"}, 32'(vec_valid), 1);
    chk({tag, "_vec"}, 32'(vec), exp);
    chk({tag, "_int"}, 32'(int_o), 0);
    cyc();
    chk({tag, "_vv_drop"}, 32'(vec_valid), 0);
  endtask

  task automatic pulse(input logic [7:0] lines);
    irq = lines;
    cyc();
    irq = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; irq = '0; cfg_wr = 0; cfg_rd = 0; inta = 0; cfg_addr = '0; cfg_wdata = '0;
    irq16 = '0; cfg_wr16 = 0; cfg_rd16 = 0; inta16 = 0; cfg_addr16 = '0; cfg_wdata16 = '0;
    repeat (2) cyc();
    chk("rst_int", 32'(int_o), 0);
    chk("rst_vec", 32'(vec), 0);
    chk("rst_vv", 32'(vec_valid), 0);
    chk("rst_rdata", 32'(cfg_rdata), 0);
    rst = 1'b0;
    cyc();
    rd_chk("rst_imr", 3'd2, 'hFF);
    rd_chk("rst_prio", 3'd6, 7);
    rd_chk("rst_ctrl", 3'd0, 0);

    // Edge mode single line, latency and vector
    wr(3'd1, 16'h0020);
    wr(3'd2, 16'h0000);
    wr(3'd0, 16'h0000);
    rd_chk("vbase_rb", 3'd1, 'h20);
    irq = 8'h08;
    cyc();
    irq = '0;
    chk("lat_t1", 32'(int_o), 0);
    cyc();
    chk("lat_t2", 32'(int_o), 0);
    cyc();
    chk("lat_t3", 32'(int_o), 1);
    ack("t1", 'h23);
    rd_chk("t1_isr", 3'd5, 'h08);
    rd_chk("t1_irr", 3'd4, 'h00);
    wr(3'd3, 16'h0000);
    rd_chk("t1_isr_eoi", 3'd5, 'h00);

    // Two lines, fixed priority, ISR blocks the lower one until EOI
    pulse(8'h24);
    wait_int("t2_int");
    ack("t2a", 'h22);
    repeat (3) cyc();
    chk("t2_blocked", 32'(int_o), 0);
    rd_chk("t2_irr", 3'd4, 'h20);
    rd_chk("t2_isr", 3'd5, 'h04);
    wr(3'd3, 16'h8003);
    rd_chk("t2_spec_noop", 3'd5, 'h04);
    chk("t2_still_blocked", 32'(int_o), 0);
    wr(3'd3, 16'h0000);
    wait_int("t2_int2");
    ack("t2b", 'h25);
    rd_chk("t2_isr5", 3'd5, 'h20);
    wr(3'd3, 16'h8005);
    rd_chk("t2_isr_clr", 3'd5, 'h00);

    // Rotation on EOI
    wr(3'd0, 16'h0004);
    pulse(8'h10);
    wait_int("t3_int");
    ack("t3a", 'h24);
    wr(3'd3, 16'h0000);
    rd_chk("t3_prio4", 3'd6, 4);
    pulse(8'h50);
    wait_int("t3_int2");
    ack("t3b", 'h26);
    wr(3'd3, 16'h0000);
    wait_int("t3_int3");
    ack("t3c", 'h24);
    wr(3'd3, 16'h0000);
    rd_chk("t3_prio_end", 3'd6, 4);
    wr(3'd6, 16'h0007);
    wr(3'd0, 16'h0000);

    // Level mode: spurious vector, and withdrawal without inta
    wr(3'd0, 16'h0001);
    irq = 8'h02;
    wait_int("t4_int");
    irq = '0;
    cyc();
    cyc();
    chk("t4_still_req", 32'(int_o), 1);
    ack("t4", 'h27);
    rd_chk("t4_isr", 3'd5, 'h00);
    irq = 8'h02;
    wait_int("t4_int2");
    irq = '0;
    repeat (3) cyc();
    chk("t4_withdraw", 32'(int_o), 0);
    wr(3'd0, 16'h0000);

    // AEOI with masking
    wr(3'd2, 16'h00FE);
    wr(3'd0, 16'h0002);
    pulse(8'h03);
    wait_int("t5_int");
    ack("t5a", 'h20);
    rd_chk("t5_isr", 3'd5, 'h00);
    repeat (2) cyc();
    chk("t5_masked", 32'(int_o), 0);
    rd_chk("t5_irr", 3'd4, 'h02);
    wr(3'd2, 16'h00FC);
    wait_int("t5_unmask_int");
    ack("t5b", 'h21);
    rd_chk("t5_isr2", 3'd5, 'h00);
    wr(3'd0, 16'h0000);
    wr(3'd2, 16'h0000);

    // Asynchronous reset during REQ
    pulse(8'h04);
    wait_int("t6_int");
    rst = 1'b1;
    #1;
    chk("t6_int_async", 32'(int_o), 0);
    inta = 1'b1;
    cyc();
    inta = 1'b0;
    chk("t6_no_vv", 32'(vec_valid), 0);
    rst = 1'b0;
    cyc();
    chk("t6_no_vv2", 32'(vec_valid), 0);
    rd_chk("t6_imr", 3'd2, 'hFF);
    rd_chk("t6_irr", 3'd4, 'h00);

    // 16-line instance: top index
    cfg_addr16 = 3'd2; cfg_wdata16 = 16'h0000; cfg_wr16 = 1'b1;
    cyc();
    cfg_addr16 = 3'd1; cfg_wdata16 = 16'h0040;
    cyc();
    cfg_wr16 = 1'b0;
    cfg_addr16 = 3'd2; cfg_rd16 = 1'b1;
    cyc();
    cfg_rd16 = 1'b0;
    chk("n16_imr", 32'(cfg_rdata16), 0);
    irq16 = 16'h8000;
    cyc();
    irq16 = '0;
    for (int n = 0; n < 20 && !int16; n++) cyc();
    chk("n16_int", 32'(int16), 1);
    inta16 = 1'b1;
    cyc();
    inta16 = 1'b0;
    chk("n16_vv", 32'(vec_valid16), 1);
    chk("n16_vec", 32'(vec16), 'h4F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pic_core_n.md
Name: pic_core_n

Overview:
- Parametrised, fully synchronous successor to the 8259-style control logic.
- Holds the interrupt request (IRR), in-service (ISR) and mask (IMR) registers for NUM_IRQ lines.
- Resolves priority in fixed or rotating mode and drives an int/inta handshake that returns a vector.
- Sits between the peripheral irq lines and the CPU bus interface, and is configured through a small register port.

Parameters:
- NUM_IRQ, 8, number of interrupt lines; legal range 2..16.
- IDX_W, $clog2(NUM_IRQ), width of the line index (derived; do not override).
- VEC_W, 8, width of vector base and vector output.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- irq  in  NUM_IRQ  raw request lines, synchronous to clk.
- cfg_wr  in  1  register write strobe.
- cfg_rd  in  1  register read strobe.
- cfg_addr  in  3  register select.
- cfg_wdata  in  16  write data.
- cfg_rdata  out  16  read data, registered.
- int_o  out  1  interrupt request to the CPU.
- inta  in  1  acknowledge, single-cycle pulse.
- vec  out  VEC_W  vector value.
- vec_valid  out  1  one-cycle qualifier for vec.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high and clears all state immediately.
- Reset values: IRR=0, ISR=0, IMR=all ones, CTRL=0, VBASE=0, prio_low=NUM_IRQ-1, int_o=0, vec=0, vec_valid=0, cfg_rdata=0, FSM=IDLE.
- Register map (reads return the value one cycle after cfg_rd; unused bits read 0):
  - 0 CTRL: bit0 LTIM (1 = level mode), bit1 AEOI, bit2 ROT (rotate on EOI).
  - 1 VBASE: bits VEC_W-1:0.
  - 2 IMR: bits NUM_IRQ-1:0.
  - 3 EOI (write-only): bit15 SPEC. When SPEC=1, bits IDX_W-1:0 select the ISR bit to clear. When SPEC=0, the highest-priority set ISR bit is cleared.
  - 4 IRR (read-only).
  - 5 ISR (read-only).
  - 6 PRIO: read/write prio_low.
- Input sampling: irq is registered once into irq_q.
- Edge mode: IRR[i] sets on irq_q[i] rising versus its previous value and holds until acknowledged.
- Level mode: IRR[i] follows irq_q[i] each cycle.
- Masking: IMR never blocks IRR latching; it only gates arbitration.
- Priority order: the line after prio_low has highest priority, wrapping modulo NUM_IRQ. With prio_low=NUM_IRQ-1, line 0 is highest.
- Rotation: when ROT=1, any EOI that clears bit k sets prio_low=k. AEOI clears also rotate when ROT=1.
- Pending condition: pend = some IRR&~IMR bit whose priority is strictly higher than the highest set ISR bit (or ISR is empty).
- FSM states:
  - IDLE: int_o=0. If pend, go to REQ next cycle; int_o is registered.
  - REQ: int_o=1.
    - On inta, latch winner w = highest-priority pending line at that cycle, set ISR[w] (unless AEOI), clear IRR[w] in edge mode, load vec=VBASE+w (modulo 2^VEC_W), and go to VEC.
    - If pend has vanished when inta arrives (masked or level dropped), return the spurious vector VBASE+NUM_IRQ-1 with no ISR/IRR change.
    - If pend drops while no inta is present, return to IDLE.
  - VEC: vec_valid=1 for exactly one cycle, then IDLE (re-arbitrates next cycle).
- inta in IDLE or VEC is ignored.
- Latency: irq rising at edge t gives irq_q at t+1, IRR at t+2, and int_o=1 at t+3.
- Simultaneous events:
  - inta and an EOI write in the same cycle: the EOI is evaluated against ISR before the inta update, and both apply.
  - Edge and inta clear of the same IRR bit: set wins.
  - IMR write and arbitration in the same cycle: arbitration uses the old IMR.
- Specific EOI to a clear ISR bit is a no-op. Non-specific EOI with ISR empty is a no-op.
- Reset during REQ/VEC aborts; no vec_valid is issued.

Decomposition:
- Package pic_pkg holds:
  - register address constants;
  - CTRL bit positions;
  - FSM state enum (IDLE, REQ, VEC);
  - EOI SPEC bit position.
- One natural sub-module, pic_prio_rot: a combinational rotating priority resolver.
  - Inputs: request vector, prio_low.
  - Outputs: found flag and winner index.
  - Used twice: once for IRR&~IMR and once for ISR.

Test Plan:
- Edge mode, IMR=0, VBASE=0x20: pulse irq[3] → int_o at +3 cycles; inta → vec=0x23 with vec_valid for 1 cycle, ISR=0x08, IRR=0.
- irq[5] and irq[2] together, fixed priority → first inta gives vec=VBASE+2. irq[5] stays pending and int_o stays 0 until a non-specific EOI clears ISR[2]; the next inta then gives VBASE+5.
- ROT=1, service and EOI line 4 → PRIO reads 4. Simultaneous irq[4] and irq[6] then win 6 before 4.
- Level mode: raise irq[1], int_o=1, drop irq[1] before inta, then inta → spurious vector VBASE+NUM_IRQ-1, ISR unchanged.
- AEOI=1, IMR=0xFE, irq[0] and irq[1] → only line 0 is serviced, ISR stays 0; unmasking line 1 then raises int_o.
- Assert reset during REQ → int_o=0 immediately, IMR=all ones, no vec_valid; NUM_IRQ=16 variant: irq[15] → vec=VBASE+15.
